// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with zero-latency
// sync, data-enable, coordinate and start-pulse decodes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_size_err
    $error("vga_timing_gen: totals do not fit in CW bits");
  end

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_MAX   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [FW-1:0] f_q, f_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    f_d = f_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
      f_d = '0;
    end else if (strobe) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
          f_d = f_q + FW'(1);
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
      f_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      f_q <= f_d;
    end
  end

  logic hs_act;
  logic vs_act;

  // Inclusive upper bounds avoid wrap when a sync ends at the total.
  always_comb begin
    hs_act      = en && (h_q >= HS_BEG) && (h_q <= HS_LAST);
    vs_act      = en && (v_q >= VS_BEG) && (v_q <= VS_LAST);
    hsync       = HS_POL ? hs_act : ~hs_act;
    vsync       = VS_POL ? vs_act : ~vs_act;
    de          = (h_q < H_ACT) && (v_q < V_ACT) && en;
    xpos        = (h_q > H_MAX) ? H_MAX : h_q;
    ypos        = (v_q > V_MAX) ? V_MAX : v_q;
    line_start  = rst && en && strobe && (h_q == '0);
    frame_start = line_start && (v_q == '0);
    frame_cnt   = f_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance and a
// small active-high-sync instance share all inputs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic strobe = 1'b0;
  logic en = 1'b1;

  logic hs0, vs0, de0, ls0, fs0;
  logic [9:0] xp0, yp0;
  logic [7:0] fc0;
  logic hs1, vs1, de1, ls1, fs1;
  logic [5:0] xp1, yp1;
  logic [7:0] fc1;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst), .strobe(strobe), .en(en),
    .hsync(hs0), .vsync(vs0), .de(de0), .xpos(xp0), .ypos(yp0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(6), .FW(8)
  ) dut1 (
    .clk(clk), .rst(rst), .strobe(strobe), .en(en),
    .hsync(hs1), .vsync(vs1), .de(de1), .xpos(xp1), .ypos(yp1),
    .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h n=%0d", tag, got, exp, n);
    end
  endtask

  function automatic logic [63:0] exp_vec(
    input int k, input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb,
    input bit hp, input bit vp, input bit e, input bit s, input bit r);
    int ht, vt, h, v, f, x, y;
    bit ha_, va_, hsv, vsv, d, l, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h = k % ht;
    v = (k / ht) % vt;
    f = (k / (ht * vt)) % 256;
    ha_ = e && h >= ha + hf && h < ha + hf + hs;
    va_ = e && v >= va + vf && v < va + vf + vs;
    hsv = hp ? ha_ : !ha_;
    vsv = vp ? va_ : !va_;
    d = e && h < ha && v < va;
    x = (h < ha) ? h : ha - 1;
    y = (v < va) ? v : va - 1;
    l = r && e && s && h == 0;
    fs = l && v == 0;
    return {8'd0, hsv, vsv, d, l, fs, 11'd0,
            16'(x), 16'(y), 8'(f)};
  endfunction

  task automatic check_all();
    chk("vec0",
        {8'd0, hs0, vs0, de0, ls0, fs0, 11'd0, 16'(xp0), 16'(yp0), fc0},
        exp_vec(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                en, strobe, rst));
    chk("vec1",
        {8'd0, hs1, vs1, de1, ls1, fs1, 11'd0, 16'(xp1), 16'(yp1), fc1},
        exp_vec(n, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1,
                en, strobe, rst));
  endtask

  task automatic cyc(input bit s, input bit e, input bit r);
    @(posedge clk);
    if (!rst || !en) n = 0;
    else if (strobe) n++;
    #1;
    strobe = s;
    en = e;
    rst = r;
    #1;
    check_all();
  endtask

  initial begin
    int guard;
    int last;
    #1;
    check_all();
    chk("rst_de", 64'(de0), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("rst_ls", 64'(ls0), 64'd0);

    cyc(1'b1, 1'b1, 1'b1);
    chk("first_fs", 64'(fs0), 64'd1);

    for (int i = 0; i < 1700; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (n == 655) chk("hs_655", 64'(hs0), 64'd1);
      if (n == 656) chk("hs_656", 64'(hs0), 64'd0);
      if (n == 751) chk("hs_751", 64'(hs0), 64'd0);
      if (n == 752) chk("hs_752", 64'(hs0), 64'd1);
      if (n == 639) chk("de_639", 64'(de0), 64'd1);
      if (n == 640) chk("de_640", 64'(de0), 64'd0);
      if (n == 799) chk("x_799", 64'(xp0), 64'd639);
      if (n == 800) chk("wrap_xy", {32'(xp0), 32'(yp0)}, {32'd0, 32'd1});
      if (n == 74) chk("vs1_74", 64'(vs1), 64'd0);
      if (n == 75) chk("vs1_75", 64'(vs1), 64'd1);
    end

    for (int i = 0; i < 400; i++) cyc(i % 4 == 0, 1'b1, 1'b1);

    last = -1;
    guard = 0;
    while (n < 257 * 120 && guard < 40000) begin
      cyc(1'b1, 1'b1, 1'b1);
      guard++;
      if (fs1) begin
        if (last >= 0) chk("frm_len", 64'(n - last), 64'd120);
        last = n;
      end
      if (n == 256 * 120 - 1) chk("fc_255", 64'(fc1), 64'd255);
      if (n == 256 * 120) chk("fc_wrap", 64'(fc1), 64'd0);
    end
    chk("run_bound", 64'(n >= 257 * 120), 64'd1);

    guard = 0;
    while (n % 120 != 78 && guard < 200) begin
      cyc(1'b1, 1'b1, 1'b1);
      guard++;
    end
    chk("pre_rst_fc", 64'(fc1), 64'd1);
    #2;
    rst = 1'b0;
    n = 0;
    #1;
    check_all();
    chk("async_clr", {32'(xp1), 32'(yp1)}, 64'd0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("rst_fs", 64'(fs1), 64'd1);

    guard = 0;
    while (n != 101 && guard < 200) begin
      cyc(1'b1, 1'b1, 1'b1);
      guard++;
    end
    chk("hs1_pre_en", 64'(hs1), 64'd1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("en_hs1", 64'(hs1), 64'd0);
    chk("en_de", 64'(de1), 64'd0);
    for (int i = 0; i < 49; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("en_fs", 64'(fs0), 64'd1);
    chk("en_fc", 64'(fc1), 64'd0);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
